// File: rtl/edge_pulse_cond_if.sv
// Event-conditioner signal bundle: raw event and clear in, pulse/level/stats out.
interface edge_pulse_cond_if;
    logic       sig_in;
    logic       clr_i;
    logic       pulse_o;
    logic       level_o;
    logic [7:0] glitch_cnt_o;
    logic       overrun_o;

    modport master (
        output sig_in, clr_i,
        input  pulse_o, level_o, glitch_cnt_o, overrun_o
    );

    modport slave (
        input  sig_in, clr_i,
        output pulse_o, level_o, glitch_cnt_o, overrun_o
    );
endinterface

// File: rtl/edge_pulse_cond.sv
// Edge pulse conditioner: 2-FF sync, persistence filter, edge select, min-interval holdoff.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  STABLE_L | accepted level is 0, waiting for s2=1
//  CONF_H   | s2 went high, counting persistence toward 1
//  STABLE_H | accepted level is 1, waiting for s2=0
//  CONF_L   | s2 went low, counting persistence toward 0
module edge_pulse_cond #(
    parameter int FILT_LEN = 4,
    parameter int HOLDOFF  = 1024,
    parameter int EDGE_SEL = 0
) (
    input logic               clk,
    input logic               rst_n,
    edge_pulse_cond_if.slave  bus
);
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;
    localparam int HW = (HOLDOFF >= 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);
    localparam logic [HW-1:0] HLOAD = (HOLDOFF >= 2) ? HW'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {STABLE_L, CONF_H, STABLE_H, CONF_L} state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          s1, s2;
    logic          acc_rise, acc_fall, glitch;
    logic          qual, ready, fire;
    logic [HW-1:0] hcnt;
    logic          pulse_q, overrun_q;
    logic [7:0]    gcnt_q;

    // Synchroniser and filter state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state_q <= STABLE_L;
            fcnt_q  <= '0;
        end else begin
            s1      <= bus.sig_in;
            s2      <= s1;
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Filter next-state: a new level must persist FILT_LEN cycles of s2
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        acc_rise = 1'b0;
        acc_fall = 1'b0;
        glitch   = 1'b0;
        case (state_q)
            STABLE_L: if (s2) begin
                if (FILT_LEN == 1) begin
                    state_d  = STABLE_H;
                    acc_rise = 1'b1;
                end else begin
                    state_d = CONF_H;
                    fcnt_d  = FW'(1);
                end
            end
            CONF_H: begin
                if (!s2) begin
                    state_d = STABLE_L;
                    glitch  = 1'b1;
                end else if (fcnt_q == FLAST) begin
                    state_d  = STABLE_H;
                    acc_rise = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            STABLE_H: if (!s2) begin
                if (FILT_LEN == 1) begin
                    state_d  = STABLE_L;
                    acc_fall = 1'b1;
                end else begin
                    state_d = CONF_L;
                    fcnt_d  = FW'(1);
                end
            end
            CONF_L: begin
                if (s2) begin
                    state_d = STABLE_H;
                    glitch  = 1'b1;
                end else if (fcnt_q == FLAST) begin
                    state_d  = STABLE_L;
                    acc_fall = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            default: state_d = STABLE_L;
        endcase
    end

    assign qual  = (EDGE_SEL == 0) ? acc_rise :
                   (EDGE_SEL == 1) ? acc_fall : (acc_rise | acc_fall);
    assign ready = (hcnt == '0);
    assign fire  = qual & ready;

    // Pulse generation, holdoff timer and debug statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_q   <= 1'b0;
            hcnt      <= '0;
            overrun_q <= 1'b0;
            gcnt_q    <= 8'd0;
        end else begin
            pulse_q <= fire;
            if (fire)
                hcnt <= HLOAD;
            else if (hcnt != '0)
                hcnt <= hcnt - HW'(1);
            if (qual && !ready)
                overrun_q <= 1'b1;
            else if (bus.clr_i)
                overrun_q <= 1'b0;
            if (bus.clr_i)
                gcnt_q <= glitch ? 8'd1 : 8'd0;
            else if (glitch && gcnt_q != 8'hFF)
                gcnt_q <= gcnt_q + 8'd1;
        end
    end

    assign bus.pulse_o      = pulse_q;
    assign bus.level_o      = (state_q == STABLE_H) || (state_q == CONF_L);
    assign bus.glitch_cnt_o = gcnt_q;
    assign bus.overrun_o    = overrun_q;
endmodule
